// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM link input and measured-duty outputs of pwm_capture
interface pwm_capture_if #(
  parameter int WIDTH = 3
);
  logic             pwmin;
  logic [WIDTH-1:0] duty;
  logic             duty_valid;
  logic             period_err;
  logic             stuck_hi;
  logic             locked;

  modport master (
    input  pwmin,
    output duty, duty_valid, period_err, stuck_hi, locked
  );

  modport slave (
    output pwmin,
    input  duty, duty_valid, period_err, stuck_hi, locked
  );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures PWM high time per frame; reports duty, period errors, stuck-high, lock
module pwm_capture #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clkin,
  input  logic         reset,
  pwm_capture_if.master bus
);
  localparam int            CW      = WIDTH + 1;
  localparam logic [CW-1:0] PERIOD  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {S_WAIT, S_HIGH, S_LOW} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pwm_d_q, pwm_d_d;
  logic [CW-1:0]          hicnt_q, hicnt_d;
  logic [CW-1:0]          percnt_q, percnt_d;
  logic [CW-1:0]          lowcnt_q, lowcnt_d;
  logic [WIDTH-1:0]       duty_q, duty_d;
  logic                   duty_valid_q, duty_valid_d;
  logic                   period_err_q, period_err_d;
  logic                   stuck_hi_q, stuck_hi_d;
  logic                   locked_q, locked_d;

  logic          pwm_s, rise, fall, timeout;
  logic [CW-1:0] hicnt_inc, percnt_inc, lowcnt_inc;

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d_q;
  assign fall  = ~pwm_s & pwm_d_q;

  assign hicnt_inc  = (hicnt_q  == CNT_MAX) ? hicnt_q  : hicnt_q  + CNT_ONE;
  assign percnt_inc = (percnt_q == CNT_MAX) ? percnt_q : percnt_q + CNT_ONE;
  assign lowcnt_inc = (lowcnt_q == CNT_MAX) ? lowcnt_q : lowcnt_q + CNT_ONE;

  // A full frame of low input is the encoding of duty 0.
  assign timeout = ~pwm_s & (lowcnt_inc == PERIOD);

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], bus.pwmin};
    pwm_d_d      = pwm_s;
    state_d      = state_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    period_err_d = 1'b0;
    stuck_hi_d   = stuck_hi_q;
    locked_d     = locked_q;

    hicnt_d  = rise ? CNT_ONE : (pwm_s ? hicnt_inc : hicnt_q);
    percnt_d = rise ? CNT_ONE : percnt_inc;
    lowcnt_d = (rise || fall) ? '0 : (pwm_s ? lowcnt_q : lowcnt_inc);

    case (state_q)
      S_WAIT: begin
        if (rise) begin
          state_d = S_HIGH;
        end else if (timeout) begin
          duty_d       = '0;
          duty_valid_d = 1'b1;
          lowcnt_d     = '0;
        end
      end
      S_HIGH: begin
        if (fall) begin
          state_d      = S_LOW;
          duty_d       = hicnt_q[WIDTH-1:0];
          duty_valid_d = 1'b1;
          stuck_hi_d   = 1'b0;
        end else if (hicnt_d == PERIOD) begin
          stuck_hi_d = 1'b1;
          locked_d   = 1'b0;
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
          if (percnt_q != PERIOD) begin
            period_err_d = 1'b1;
            locked_d     = 1'b0;
          end else begin
            locked_d = 1'b1;
          end
        end else if (timeout) begin
          duty_d       = '0;
          duty_valid_d = 1'b1;
          lowcnt_d     = '0;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q      <= S_WAIT;
      sync_q       <= '0;
      pwm_d_q      <= 1'b0;
      hicnt_q      <= '0;
      percnt_q     <= '0;
      lowcnt_q     <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      stuck_hi_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      pwm_d_q      <= pwm_d_d;
      hicnt_q      <= hicnt_d;
      percnt_q     <= percnt_d;
      lowcnt_q     <= lowcnt_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      period_err_q <= period_err_d;
      stuck_hi_q   <= stuck_hi_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.period_err = period_err_q;
  assign bus.stuck_hi   = stuck_hi_q;
  assign bus.locked     = locked_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed frame-table and corner-sequence bench for pwm_capture
module tb_pwm_capture;
  logic clkin = 1'b0;
  logic reset;

  pwm_capture_if #(.WIDTH(3)) bus ();

  pwm_capture #(.WIDTH(3), .SYNC_STAGES(2)) dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [2:0] duty;
    logic       locked;
    logic       perr;
  } rec_t;

  typedef struct {
    int hi;
    int lo;
    int exp_duty;
    int exp_perr;
    int exp_locked;
  } vec_t;

  rec_t recs[$];
  vec_t vecs[$];
  logic perr_pending = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // One record per duty_valid, tagged with any period_err seen since the previous one.
  always @(negedge clkin) begin
    if (reset) begin
      perr_pending <= 1'b0;
    end else if (bus.duty_valid) begin
      recs.push_back({bus.duty, bus.locked, perr_pending});
      perr_pending <= 1'b0;
    end else if (bus.period_err) begin
      perr_pending <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int hi, input int lo, input int d, input int p, input int l);
    vec_t v;
    v.hi = hi; v.lo = lo; v.exp_duty = d; v.exp_perr = p; v.exp_locked = l;
    return v;
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic drive_frame(input int hi, input int lo);
    for (int i = 0; i < hi; i++) begin bus.pwmin = 1'b1; tick(); end
    for (int i = 0; i < lo; i++) begin bus.pwmin = 1'b0; tick(); end
  endtask

  task automatic do_reset();
    bus.pwmin = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_duty"},       int'(bus.duty),       0);
    check({tag, "_duty_valid"}, int'(bus.duty_valid), 0);
    check({tag, "_period_err"}, int'(bus.period_err), 0);
    check({tag, "_stuck_hi"},   int'(bus.stuck_hi),   0);
    check({tag, "_locked"},     int'(bus.locked),     0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.pwmin = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset");
    reset = 1'b0;

    // Generator stream N=3, sweep N=1..7, then a 6-cycle spacing after lock.
    for (int i = 0; i < 4; i++) vecs.push_back(mk(3, 5, 3, 0, (i == 0) ? 0 : 1));
    for (int n = 1; n <= 7; n++)
      for (int f = 0; f < 3; f++) vecs.push_back(mk(n, 8 - n, n, 0, 1));
    vecs.push_back(mk(3, 3, 3, 0, 1));
    vecs.push_back(mk(3, 5, 3, 1, 0));
    vecs.push_back(mk(3, 5, 3, 0, 1));
    vecs.push_back(mk(3, 5, 3, 0, 1));

    base = recs.size();
    foreach (vecs[i]) drive_frame(vecs[i].hi, vecs[i].lo);
    drive_frame(0, 4);
    check("table_record_count", recs.size() - base, vecs.size());
    foreach (vecs[i]) begin
      if (base + i < recs.size()) begin
        check($sformatf("vec%0d_duty", i),   int'(recs[base+i].duty),   vecs[i].exp_duty);
        check($sformatf("vec%0d_perr", i),   int'(recs[base+i].perr),   vecs[i].exp_perr);
        check($sformatf("vec%0d_locked", i), int'(recs[base+i].locked), vecs[i].exp_locked);
      end
    end

    // Held low after reset: duty 0 reported every 8 cycles.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      bus.pwmin = 1'b0;
      tick();
      check($sformatf("low%0d_valid", k), int'(bus.duty_valid), (k == 8 || k == 16) ? 1 : 0);
      check($sformatf("low%0d_flags", k), int'({bus.period_err, bus.locked, bus.stuck_hi}), 0);
      if (k == 8 || k == 16) check($sformatf("low%0d_duty", k), int'(bus.duty), 0);
    end

    // Lock on N=3, then hold high for 12 cycles.
    do_reset();
    for (int f = 0; f < 3; f++) drive_frame(3, 5);
    for (int k = 1; k <= 16; k++) begin
      bus.pwmin = (k <= 12);
      tick();
      check($sformatf("stuck%0d_stuck_hi", k), int'(bus.stuck_hi), (k >= 10 && k <= 14) ? 1 : 0);
      check($sformatf("stuck%0d_valid", k), int'(bus.duty_valid), (k == 15) ? 1 : 0);
      check($sformatf("stuck%0d_locked", k), int'(bus.locked), (k < 10) ? 1 : 0);
      if (k == 15) check("stuck_duty", int'(bus.duty), 4);
    end

    // Reset in the middle of the high phase of an N=5 frame.
    do_reset();
    drive_frame(5, 3);
    drive_frame(5, 3);
    check("pre_mid_duty", int'(bus.duty), 5);
    check("pre_mid_locked", int'(bus.locked), 1);
    drive_frame(3, 0);
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    drive_frame(2, 1);
    reset = 1'b0;
    base = recs.size();
    drive_frame(5, 3);
    drive_frame(0, 4);
    check("after_reset_records", recs.size() - base, 1);
    if (recs.size() > base) begin
      check("after_reset_duty",   int'(recs[base].duty),   5);
      check("after_reset_locked", int'(recs[base].locked), 0);
      check("after_reset_perr",   int'(recs[base].perr),   0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's 8-slot PWM generator.
- Samples a PWM waveform arriving on pwmin, measures the high time of each frame, and reports it as a WIDTH-bit duty code with a one-cycle valid strobe.
- Also reports frame-period violations, stuck-high input and lock status.
- Sits at the input boundary of a PWM link; pwmin may be asynchronous to clkin.

Parameters:
WIDTH, 3, duty code width; nominal frame PERIOD = 2**WIDTH clkin cycles
SYNC_STAGES, 2, synchronizer flops on pwmin (legal range 2..4)

Ports:
clkin  input  1  sampling clock, rising edge
reset  input  1  asynchronous, active-high reset
pwmin  input  1  PWM waveform, high for N cycles of each PERIOD-cycle frame, N in 0..PERIOD-1
duty  output  WIDTH  last measured high time in clkin cycles
duty_valid  output  1  one-cycle pulse when duty is updated
period_err  output  1  one-cycle pulse when rise-to-rise spacing differs from PERIOD
stuck_hi  output  1  level; pwmin high for PERIOD or more consecutive cycles
locked  output  1  level; last rise-to-rise spacing equalled PERIOD

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clkin.
- Reset clears every register. duty=0, duty_valid=0, period_err=0, stuck_hi=0, locked=0. Synchronizer flops clear to 0. State is S_WAIT.
- Synchronizer:
  - pwm_s is the SYNC_STAGES-deep synchronized pwmin; pwm_d is pwm_s delayed one cycle.
  - rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
- Counters, each WIDTH+1 bits and saturating at all-ones (no wrap):
  - hicnt: loads 1 on rise, increments while pwm_s=1.
  - percnt: loads 1 on rise, increments otherwise.
  - lowcnt: cleared on fall or rise, increments while pwm_s=0; cleared on reaching PERIOD (see timeout).
- FSM states: S_WAIT (no rise seen since reset), S_HIGH, S_LOW.
  - S_WAIT -> S_HIGH on rise. No period check on this first rise.
  - S_HIGH -> S_LOW on fall. Registered outputs update the following cycle: duty <= hicnt[WIDTH-1:0], duty_valid=1, stuck_hi=0.
  - S_LOW -> S_HIGH on rise. If percnt != PERIOD: period_err=1 and locked<=0. Otherwise locked<=1.
- Low timeout (S_WAIT or S_LOW): when lowcnt reaches PERIOD, duty<=0, duty_valid=1, lowcnt restarts at 0. Repeats every PERIOD cycles while low. This is the frame encoding of duty 0. locked is unchanged.
- Stuck high (S_HIGH): when hicnt reaches PERIOD, stuck_hi<=1 and locked<=0. duty is not updated until the next fall; at that fall duty holds the saturated value truncated to WIDTH bits.
- Latency:
  - pwmin edge to rise/fall detection is SYNC_STAGES+1 cycles.
  - duty/duty_valid register one cycle after fall detection.
  - Measured high time equals the number of pwm_s high cycles exactly.
- Simultaneous events:
  - Rise and a low timeout in the same cycle: the rise wins and lowcnt clears.
  - Fall and stuck detection in the same cycle: the fall wins.
  - period_err and duty_valid never coincide, because rise and fall are exclusive.
- Asynchronous reset mid-frame aborts any measurement. The first duty_valid after reset comes from the first complete high pulse, or from a low timeout.

Test Plan:
- Generator-style stream, N=3 (3 high, 5 low, repeating), 4 frames -> duty=3 and duty_valid once per frame, period 8 cycles; locked=1 from the second rise onward; period_err never asserts.
- Sweep N=1..7, 3 frames each -> duty equals N after each fall; no period_err; locked stays 1 across duty changes (spacing remains 8).
- pwmin held low 20 cycles after reset -> duty_valid at lowcnt=8 and 16 with duty=0; locked=0; no period_err.
- Frames with a 6-cycle rise-to-rise spacing injected after lock -> period_err pulse on that rise; locked drops to 0 and returns to 1 after the next 8-cycle spacing.
- pwmin held high 12 cycles, then low -> stuck_hi rises 8 cycles after rise detection; at the fall it clears, with duty_valid=1 and duty=12 mod 8=4; locked=0.
- Assert reset during the high phase of an N=5 frame -> all outputs 0 immediately; FSM in S_WAIT; the partial pulse is never reported; the first valid after the next full pulse gives duty=5.
